hog_cell_hist: RTL

Per-cell orientation histogram accumulator sitting directly downstream of the gradient-magnitude square-root pipeline. Each pixel's orientation bin and valid flag are captured when its squared magnitude enters the square-root unit. The block delays them internally to match the square-root latency, then adds the returned magnitude into one of BIN_N bin accumulators. After CELL_PIX pixels it emits the cell histogram as a single flattened word with a one-cycle valid pulse, ready for block normalisation.

---
 rtl/hog_cell_hist.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hog_cell_hist.sv
// Per-cell orientation histogram accumulator behind the gradient-magnitude sqrt pipeline.
// Optional build macro HOG_HIST_SAT_EN: saturating bin adds (default build wraps modulo 2^ACC_W).
module hog_cell_hist #(
    parameter int unsigned MAG_W    = 13,
    parameter int unsigned LAT      = 13,
    parameter int unsigned BIN_N    = 9,
    parameter int unsigned CELL_PIX = 64,
    parameter int unsigned ACC_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    input  logic [3:0]               pix_bin,
    input  logic [MAG_W-1:0]         mag,
    output logic                     hist_valid,
    output logic [BIN_N*ACC_W-1:0]   hist_data,
    output logic                     bin_err
);

    localparam int unsigned CNT_W = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;
    localparam int unsigned HIST_W = BIN_N * ACC_W;

    logic                   dl_valid_q [LAT];
    logic                   dl_valid_d [LAT];
    logic [3:0]             dl_bin_q   [LAT];
    logic [3:0]             dl_bin_d   [LAT];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q [BIN_N];
    logic [ACC_W-1:0]       acc_d [BIN_N];
    logic [HIST_W-1:0]      hist_data_q, hist_data_d;
    logic                   hist_valid_q, hist_valid_d;
    logic                   bin_err_q, bin_err_d;

    logic                   d_valid;
    logic [3:0]             d_bin;
    logic                   first_pix;
    logic                   last_pix;

    // One bin update: zero-extended magnitude onto the running sum.
    function automatic logic [ACC_W-1:0] bin_add(input logic [ACC_W-1:0] base,
                                                 input logic [MAG_W-1:0] m);
`ifdef HOG_HIST_SAT_EN
        logic [ACC_W:0] s;
        s = {1'b0, base} + (ACC_W+1)'(m);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return base + ACC_W'(m);
`endif
    endfunction

    assign d_valid   = dl_valid_q[LAT-1];
    assign d_bin     = dl_bin_q[LAT-1];
    assign first_pix = (cnt_q == '0);
    assign last_pix  = (cnt_q == CNT_W'(CELL_PIX - 1));

    always_comb begin
        dl_valid_d   = dl_valid_q;
        dl_bin_d     = dl_bin_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        hist_data_d  = hist_data_q;
        hist_valid_d = 1'b0;
        bin_err_d    = bin_err_q;

        // Free-running alignment of {valid, bin} with the sqrt latency.
        dl_valid_d[0] = pix_valid;
        dl_bin_d[0]   = pix_bin;
        for (int i = 1; i < LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_bin_d[i]   = dl_bin_q[i-1];
        end

        if (d_valid) begin
            cnt_d = last_pix ? '0 : cnt_q + CNT_W'(1);
            // First pixel of a cell clears every bin in the same cycle it writes one.
            for (int k = 0; k < BIN_N; k++) begin
                if (first_pix) begin
                    acc_d[k] = '0;
                end
                if (d_bin == 4'(k)) begin
                    acc_d[k] = bin_add(first_pix ? '0 : acc_q[k], mag);
                end
            end
            if (32'(d_bin) >= BIN_N) begin
                bin_err_d = 1'b1;
            end
            if (last_pix) begin
                hist_valid_d = 1'b1;
                for (int k = 0; k < BIN_N; k++) begin
                    hist_data_d[k*ACC_W +: ACC_W] = acc_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid_q   <= '{default: 1'b0};
            dl_bin_q     <= '{default: 4'd0};
            cnt_q        <= '0;
            acc_q        <= '{default: '0};
            hist_data_q  <= '0;
            hist_valid_q <= 1'b0;
            bin_err_q    <= 1'b0;
        end else begin
            dl_valid_q   <= dl_valid_d;
            dl_bin_q     <= dl_bin_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            hist_data_q  <= hist_data_d;
            hist_valid_q <= hist_valid_d;
            bin_err_q    <= bin_err_d;
        end
    end

    assign hist_valid = hist_valid_q;
    assign hist_data  = hist_data_q;
    assign bin_err    = bin_err_q;

endmodule
